// File: rtl/blk_shift_seq_if.sv
`default_nettype none
// ============================================================================
//  Module   : blk_shift_seq_if
//  Purpose  : Command and 1R1W memory-port bundle for blk_shift_seq.
//  Revision : 1.0  initial release
// ============================================================================
interface blk_shift_seq_if #(
    parameter int W  = 32,
    parameter int AW = 14
);
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_op;
    logic [W-1:0]  cmd_data;
    logic [AW-1:0] mem_raddr;
    logic [W-1:0]  mem_rdata;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [W-1:0]  mem_wdata;
    logic          busy;
    logic          done;
    logic [W-1:0]  tail_out;

    // Sequencer view
    modport slave (
        input  cmd_valid, cmd_op, cmd_data, mem_rdata,
        output cmd_ready, mem_raddr, mem_we, mem_waddr, mem_wdata,
               busy, done, tail_out
    );

    // Command source / memory view
    modport master (
        output cmd_valid, cmd_op, cmd_data, mem_rdata,
        input  cmd_ready, mem_raddr, mem_we, mem_waddr, mem_wdata,
               busy, done, tail_out
    );
endinterface

`default_nettype wire

// File: rtl/blk_shift_seq.sv
`default_nettype none
// ============================================================================
//  Module   : blk_shift_seq
//  Purpose  : Multi-cycle shift-in / fill sequencer for a DEPTH x W array in
//             a 1R1W memory. Optional macro BLK_SHIFT_SEQ_TAIL_EN captures
//             the entry shifted out of the top into tail_out.
//  Revision : 1.0  initial release
// ============================================================================
module blk_shift_seq #(
    parameter int DEPTH = 10000,
    parameter int W     = 32
) (
    input  wire            clk,
    input  wire            rst,
    blk_shift_seq_if.slave bus
);

    localparam int            AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [AW-1:0] FIRST_RD  = AW'(DEPTH - 2);

    if (DEPTH < 2) begin : g_depth_check
        $error("blk_shift_seq: DEPTH must be >= 2");
    end

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_TAIL  = 3'd1,
        ST_SHIFT = 3'd2,
        ST_DRAIN = 3'd3,
        ST_HEAD  = 3'd4,
        ST_FILL  = 3'd5
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] raddr_q, raddr_d;
    logic [AW-1:0] waddr_q, waddr_d;
    logic          we_q, we_d;
    logic          wsel_q, wsel_d;
    logic          done_q, done_d;
    logic          busy_q, busy_d;
    logic [W-1:0]  data_q, data_d;
    logic          accept;
`ifdef BLK_SHIFT_SEQ_TAIL_EN
    logic [W-1:0]  tail_q, tail_d;
`endif

    assign bus.cmd_ready = (state_q == ST_IDLE) && !rst;
    assign accept        = bus.cmd_valid && bus.cmd_ready;

    always_comb begin
        state_d = state_q;
        raddr_d = raddr_q;
        waddr_d = waddr_q;
        we_d    = 1'b0;
        wsel_d  = 1'b0;
        done_d  = 1'b0;
        data_d  = data_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    data_d = bus.cmd_data;
                    if (bus.cmd_op) begin
                        state_d = ST_FILL;
                        we_d    = 1'b1;
                        waddr_d = '0;
                    end else begin
`ifdef BLK_SHIFT_SEQ_TAIL_EN
                        state_d = ST_TAIL;
                        raddr_d = LAST_ADDR;
`else
                        state_d = ST_SHIFT;
                        raddr_d = FIRST_RD;
`endif
                    end
                end
            end
            ST_TAIL: begin
                state_d = ST_SHIFT;
                raddr_d = FIRST_RD;
            end
            ST_SHIFT: begin
                // Data read this cycle lands next cycle and is written one slot up
                we_d    = 1'b1;
                wsel_d  = 1'b1;
                waddr_d = raddr_q + AW'(1);
                if (raddr_q == '0) begin
                    state_d = ST_DRAIN;
                end else begin
                    raddr_d = raddr_q - AW'(1);
                end
            end
            ST_DRAIN: begin
                state_d = ST_HEAD;
                we_d    = 1'b1;
                waddr_d = '0;
                done_d  = 1'b1;
            end
            ST_HEAD: begin
                state_d = ST_IDLE;
            end
            ST_FILL: begin
                if (waddr_q == LAST_ADDR) begin
                    state_d = ST_IDLE;
                end else begin
                    we_d    = 1'b1;
                    waddr_d = waddr_q + AW'(1);
                    done_d  = ((waddr_q + AW'(1)) == LAST_ADDR);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

`ifdef BLK_SHIFT_SEQ_TAIL_EN
    // First SHIFT cycle is the one where the DEPTH-1 read data returns
    always_comb begin
        tail_d = tail_q;
        if (state_q == ST_SHIFT && raddr_q == FIRST_RD) begin
            tail_d = bus.mem_rdata;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            raddr_q <= '0;
            waddr_q <= '0;
            we_q    <= 1'b0;
            wsel_q  <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            data_q  <= '0;
`ifdef BLK_SHIFT_SEQ_TAIL_EN
            tail_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            raddr_q <= raddr_d;
            waddr_q <= waddr_d;
            we_q    <= we_d;
            wsel_q  <= wsel_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            data_q  <= data_d;
`ifdef BLK_SHIFT_SEQ_TAIL_EN
            tail_q  <= tail_d;
`endif
        end
    end

    assign bus.mem_raddr = raddr_q;
    assign bus.mem_waddr = waddr_q;
    assign bus.mem_we    = we_q;
    // Shift writes forward the read data directly to keep one entry per cycle
    assign bus.mem_wdata = wsel_q ? bus.mem_rdata : data_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
`ifdef BLK_SHIFT_SEQ_TAIL_EN
    assign bus.tail_out  = tail_q;
`else
    assign bus.tail_out  = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_blk_shift_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_blk_shift_seq
//  Purpose  : Self-checking bench for blk_shift_seq (DEPTH=8) against a
//             queue-based array model and a behavioural 1R1W memory.
//  Revision : 1.0  initial release
// ============================================================================
module tb_blk_shift_seq;

    localparam int DEPTH = 8;
    localparam int W     = 32;
    localparam int AW    = $clog2(DEPTH);
`ifdef BLK_SHIFT_SEQ_TAIL_EN
    localparam int SHIFT_LAT = DEPTH + 2;
`else
    localparam int SHIFT_LAT = DEPTH + 1;
`endif
    localparam int FILL_LAT = DEPTH;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    blk_shift_seq_if #(.W(W), .AW(AW)) bus ();

    blk_shift_seq #(.DEPTH(DEPTH), .W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [W-1:0] mem [DEPTH];
    logic [W-1:0] rdata_q;
    int           wlog [$];

    always @(posedge clk) begin
        rdata_q <= mem[bus.mem_raddr];
        if (bus.mem_we) begin
            mem[bus.mem_waddr] <= bus.mem_wdata;
            wlog.push_back(int'(bus.mem_waddr));
        end
    end
    assign bus.mem_rdata = rdata_q;

    int           checks   = 0;
    int           failures = 0;
    logic [W-1:0] model_q [$];
    logic [W-1:0] exp_tail = '0;

    function automatic void model_shift(input logic [W-1:0] d);
`ifdef BLK_SHIFT_SEQ_TAIL_EN
        exp_tail = model_q[DEPTH-1];
`endif
        model_q.push_front(d);
        void'(model_q.pop_back());
    endfunction

    function automatic void model_fill(input logic [W-1:0] d);
        foreach (model_q[i]) model_q[i] = d;
    endfunction

    task automatic load_ident();
        model_q = {};
        for (int i = 0; i < DEPTH; i++) begin
            mem[i] = W'(i);
            model_q.push_back(W'(i));
        end
    endtask

    task automatic load_rand();
        model_q = {};
        for (int i = 0; i < DEPTH; i++) begin
            mem[i] = $urandom;
            model_q.push_back(mem[i]);
        end
    endtask

    // Issue one command and observe it to completion; no judgement here
    task automatic run_cmd(input logic op, input logic [W-1:0] d,
                           output int lat, output int dones, output int done_at,
                           output logic [AW-1:0] done_waddr, output logic done_we,
                           output logic [W-1:0] done_tail, output bit timeout);
        int n;
        lat = 0; dones = 0; done_at = -1; timeout = 1'b0;
        done_waddr = '0; done_we = 1'b0; done_tail = '0;
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_data  = d;
        n = 0;
        while (bus.cmd_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) timeout = 1'b1;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        bus.cmd_data  = $urandom;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (bus.busy === 1'b1) lat++;
            if (bus.done === 1'b1) begin
                dones++;
                done_at    = lat;
                done_waddr = bus.mem_waddr;
                done_we    = bus.mem_we;
                done_tail  = bus.tail_out;
            end
        end while (bus.busy === 1'b1 && n < 100);
        if (n >= 100) timeout = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.cmd_ready !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.mem_we !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctrl ready=%b busy=%b done=%b we=%b required all 0",
                     bus.cmd_ready, bus.busy, bus.done, bus.mem_we);
        end
        checks++;
        if (bus.mem_raddr !== '0 || bus.mem_waddr !== '0 || bus.mem_wdata !== '0 || bus.tail_out !== '0) begin
            failures++;
            $display("FAIL reset_data raddr=%h waddr=%h wdata=%h tail=%h required all 0",
                     bus.mem_raddr, bus.mem_waddr, bus.mem_wdata, bus.tail_out);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_ready got=%b required=1", bus.cmd_ready);
        end
    endtask

    task automatic test_shift(input int iter);
        int lat, dones, done_at;
        logic [AW-1:0] dwa;
        logic dwe;
        logic [W-1:0] dtail, d;
        bit to;
        for (int k = 0; k < iter; k++) begin
            if (k == 0) begin
                load_ident();
                d = 32'hA5A5_A5A5;
            end else begin
                load_rand();
                d = $urandom;
            end
            model_shift(d);
            run_cmd(1'b0, d, lat, dones, done_at, dwa, dwe, dtail, to);
            checks++;
            if (to || lat != SHIFT_LAT) begin
                failures++;
                $display("FAIL shift_latency it=%0d got=%0d timeout=%0d required=%0d", k, lat, to, SHIFT_LAT);
            end
            checks++;
            if (dones != 1 || done_at != lat) begin
                failures++;
                $display("FAIL shift_done it=%0d pulses=%0d at=%0d required 1 pulse at %0d", k, dones, done_at, lat);
            end
            checks++;
            if (dtail !== exp_tail) begin
                failures++;
                $display("FAIL shift_tail it=%0d got=%h required=%h", k, dtail, exp_tail);
            end
            for (int i = 0; i < DEPTH; i++) begin
                checks++;
                if (mem[i] !== model_q[i]) begin
                    failures++;
                    $display("FAIL shift_arr it=%0d idx=%0d got=%h required=%h", k, i, mem[i], model_q[i]);
                end
            end
        end
    endtask

    task automatic test_fill();
        int lat, dones, done_at;
        logic [AW-1:0] dwa;
        logic dwe;
        logic [W-1:0] dtail, d;
        bit to;
        for (int k = 0; k < 2; k++) begin
            load_rand();
            d = (k == 0) ? 32'hDEAD_BEEF : $urandom;
            model_fill(d);
            wlog = {};
            run_cmd(1'b1, d, lat, dones, done_at, dwa, dwe, dtail, to);
            checks++;
            if (to || lat != FILL_LAT || dones != 1 || done_at != lat) begin
                failures++;
                $display("FAIL fill_timing it=%0d lat=%0d pulses=%0d at=%0d timeout=%0d required lat=%0d 1 pulse at end",
                         k, lat, dones, done_at, to, FILL_LAT);
            end
            checks++;
            if (dwe !== 1'b1 || int'(dwa) != DEPTH - 1) begin
                failures++;
                $display("FAIL fill_done_addr we=%b addr=%0d required we=1 addr=%0d", dwe, dwa, DEPTH - 1);
            end
            checks++;
            if (wlog.size() != DEPTH) begin
                failures++;
                $display("FAIL fill_write_count got=%0d required=%0d", wlog.size(), DEPTH);
            end
            for (int i = 0; i < wlog.size() && i < DEPTH; i++) begin
                checks++;
                if (wlog[i] != i) begin
                    failures++;
                    $display("FAIL fill_order slot=%0d got=%0d required=%0d", i, wlog[i], i);
                end
            end
            checks++;
            if (dtail !== exp_tail) begin
                failures++;
                $display("FAIL fill_tail_hold got=%h required=%h", dtail, exp_tail);
            end
            for (int i = 0; i < DEPTH; i++) begin
                checks++;
                if (mem[i] !== model_q[i]) begin
                    failures++;
                    $display("FAIL fill_arr idx=%0d got=%h required=%h", i, mem[i], model_q[i]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int n, lat2;
        bit seen_done;
        load_ident();
        model_shift(32'h11);
        model_shift(32'h22);
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 1'b0;
        bus.cmd_data  = 32'h11;
        @(posedge clk);
        #1;
        bus.cmd_data = 32'h22;
        n = 0;
        seen_done = 1'b0;
        while (!seen_done && n < 100) begin
            @(negedge clk);
            n++;
            if (bus.done === 1'b1) seen_done = 1'b1;
        end
        @(negedge clk);
        checks++;
        if (!seen_done || bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL b2b_ready_after_done done_seen=%0d ready=%b busy=%b required 1/1/0",
                     seen_done, bus.cmd_ready, bus.busy);
        end
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        lat2 = 0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (bus.busy === 1'b1) lat2++;
        end while (bus.busy === 1'b1 && n < 100);
        checks++;
        if (lat2 != SHIFT_LAT) begin
            failures++;
            $display("FAIL b2b_second_latency got=%0d required=%0d", lat2, SHIFT_LAT);
        end
        checks++;
        if (bus.tail_out !== exp_tail) begin
            failures++;
            $display("FAIL b2b_tail got=%h required=%h", bus.tail_out, exp_tail);
        end
        for (int i = 0; i < DEPTH; i++) begin
            checks++;
            if (mem[i] !== model_q[i]) begin
                failures++;
                $display("FAIL b2b_arr idx=%0d got=%h required=%h", i, mem[i], model_q[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int n, lat, dones, done_at;
        logic [AW-1:0] dwa;
        logic dwe;
        logic [W-1:0] dtail, d;
        bit to;
        load_ident();
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 1'b0;
        bus.cmd_data  = $urandom;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.mem_we !== 1'b0 || bus.cmd_ready !== 1'b0 ||
            bus.mem_raddr !== '0 || bus.mem_waddr !== '0 || bus.mem_wdata !== '0 || bus.tail_out !== '0) begin
            failures++;
            $display("FAIL mid_reset_async busy=%b done=%b we=%b ready=%b raddr=%h waddr=%h wdata=%h tail=%h required all 0",
                     bus.busy, bus.done, bus.mem_we, bus.cmd_ready, bus.mem_raddr, bus.mem_waddr,
                     bus.mem_wdata, bus.tail_out);
        end
        @(negedge clk);
        rst = 1'b0;
        exp_tail = '0;
        n = 0;
        load_ident();
        d = $urandom;
        model_shift(d);
        run_cmd(1'b0, d, lat, dones, done_at, dwa, dwe, dtail, to);
        checks++;
        if (to || lat != SHIFT_LAT || dones != 1 || done_at != lat) begin
            failures++;
            $display("FAIL mid_reset_next_shift lat=%0d pulses=%0d at=%0d timeout=%0d required lat=%0d",
                     lat, dones, done_at, to, SHIFT_LAT);
        end
        for (int i = 0; i < DEPTH; i++) begin
            checks++;
            if (mem[i] !== model_q[i]) begin
                failures++;
                $display("FAIL mid_reset_arr idx=%0d got=%h required=%h", i, mem[i], model_q[i]);
            end
        end
    endtask

    task automatic test_ignore_busy();
        int n, lat, idle_busy;
        logic [W-1:0] d;
        load_rand();
        d = $urandom;
        model_shift(d);
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 1'b0;
        bus.cmd_data  = d;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        lat = 0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (bus.busy === 1'b1) lat++;
            if (n == 3) begin
                bus.cmd_valid = 1'b1;
                bus.cmd_op    = 1'b1;
                bus.cmd_data  = $urandom;
            end else begin
                bus.cmd_valid = 1'b0;
            end
        end while (bus.busy === 1'b1 && n < 100);
        bus.cmd_valid = 1'b0;
        idle_busy = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.busy !== 1'b0) idle_busy++;
        end
        checks++;
        if (lat != SHIFT_LAT || idle_busy != 0) begin
            failures++;
            $display("FAIL ignore_busy_timing lat=%0d busy_after=%0d required lat=%0d busy_after=0",
                     lat, idle_busy, SHIFT_LAT);
        end
        for (int i = 0; i < DEPTH; i++) begin
            checks++;
            if (mem[i] !== model_q[i]) begin
                failures++;
                $display("FAIL ignore_busy_arr idx=%0d got=%h required=%h", i, mem[i], model_q[i]);
            end
        end
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 1'b0;
        bus.cmd_data  = '0;
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        test_reset();
        test_shift(3);
        test_fill();
        test_back_to_back();
        test_reset_mid();
        test_ignore_busy();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
